// File: rtl/prog_loader.sv
// prog_loader: boot-time byte-stream loader for the instruction memory.
// Parses a big-endian word count, assembles big-endian 32-bit words,
// writes them to consecutive word addresses and verifies an XOR checksum
// before releasing the processor from reset.
module prog_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned CAP   = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        ST_HDR0  = 3'd0,
        ST_HDR1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         byte_q, byte_d;
    logic [31:0]        shift_q, shift_d;
    logic [7:0]         xsum_q, xsum_d;
    logic               we_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [31:0]        wdata_d;
    logic               cpu_rst_d, done_d, err_d;
    logic               accept;
    logic [15:0]        n_hdr;

    // Ready only in byte-consuming states, and never while reset is held
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_HDR0, ST_HDR1, ST_DATA, ST_CHK: in_ready = 1'b1;
                default:                           in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid & in_ready;
    assign n_hdr  = {cnt_q[15:8], in_data};

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        xsum_d    = xsum_q;
        we_d      = 1'b0;
        addr_d    = im_addr;
        wdata_d   = im_wdata;
        cpu_rst_d = cpu_rst;
        done_d    = done;
        err_d     = err;

        case (state_q)
            ST_HDR0: begin
                if (accept) begin
                    cnt_d   = {in_data, cnt_q[7:0]};
                    state_d = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (accept) begin
                    cnt_d = n_hdr;
                    if (32'(n_hdr) > CAP) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else if (n_hdr == 16'd0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    shift_d = {shift_q[23:0], in_data};
                    xsum_d  = xsum_q ^ in_data;
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        // Launch the write so im_we is high during WRITE
                        we_d    = 1'b1;
                        addr_d  = idx_q[ADDR_W-1:0];
                        wdata_d = {shift_q[23:0], in_data};
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                idx_d = idx_q + IDX_W'(1);
                if (32'(idx_q) + 32'd1 == 32'(cnt_q)) begin
                    state_d = ST_CHK;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CHK: begin
                if (accept) begin
                    if (in_data == xsum_q) begin
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State and registered outputs; synchronous reset restarts the load
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HDR0;
            cnt_q    <= '0;
            idx_q    <= '0;
            byte_q   <= '0;
            shift_q  <= '0;
            xsum_q   <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            xsum_q   <= xsum_d;
            im_we    <= we_d;
            im_addr  <= addr_d;
            im_wdata <= wdata_d;
            cpu_rst  <= cpu_rst_d;
            done     <= done_d;
            err      <= err_d;
        end
    end

endmodule
